// File: rtl/apb_traffic_ctrl_v2.sv
`default_nettype none
// ============================================================================
// apb_traffic_ctrl_v2 : APB-programmable two-direction traffic-light controller
//                       with freeze, force-advance, night flash and cycle count.
// Revision: 1.0
// ============================================================================
module apb_traffic_ctrl_v2 #(
   parameter int          CNT_W        = 16,
   parameter int          T_GREEN_DEF  = 15,
   parameter int          T_YELLOW_DEF = 5,
   parameter int          FLASH_HALF   = 8,
   parameter logic [31:0] CTRL_ADDR    = 32'h00,
   parameter logic [31:0] STATUS_ADDR  = 32'h04,
   parameter logic [31:0] TGREEN_ADDR  = 32'h08,
   parameter logic [31:0] TYELLOW_ADDR = 32'h0C,
   parameter logic [31:0] CYCLES_ADDR  = 32'h10
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [1:0]  lights_a,
   output logic [1:0]  lights_b
);

   localparam logic [2:0] P0 = 3'd0;
   localparam logic [2:0] P1 = 3'd1;
   localparam logic [2:0] P2 = 3'd2;
   localparam logic [2:0] P3 = 3'd3;
   localparam logic [2:0] P4 = 3'd4;
   localparam logic [2:0] P5 = 3'd5;

   localparam logic [1:0] LAMP_RED    = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_GREEN  = 2'b10;
   localparam logic [1:0] LAMP_OFF    = 2'b11;

   localparam int               FW         = $clog2(FLASH_HALF + 1);
   localparam logic [FW-1:0]    FLASH_LAST = FW'(FLASH_HALF - 1);
   localparam logic [FW-1:0]    FLASH_ONE  = FW'(1);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   // Traffic state
   logic [2:0]       phase, phase_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic [CNT_W-1:0] dur;
   logic             wrap;
   logic [31:0]      cycles;
   logic             flash_active, flash_active_nxt;
   logic [FW-1:0]    flash_cnt, flash_cnt_nxt;
   logic             flash_off, flash_off_nxt;
   logic [1:0]       lamp_a_nxt, lamp_b_nxt;

   // Register file
   logic             ctrl_en, ctrl_adv, ctrl_flash;
   logic [CNT_W-1:0] t_green, t_yellow;

   // APB decode
   logic             access, apb_err, wr_en;
   logic             hit_ctrl, hit_status, hit_tgreen, hit_tyellow, hit_cycles;
   logic [31:0]      status_word, rd_word;

   logic unused_wdata;
   assign unused_wdata = &{1'b0, PWDATA[31:CNT_W]};

   function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
      return (v == '0) ? ONE : v;
   endfunction

   // ---------------------------------------------------------------- APB
   always_comb begin
      access      = PSEL & PENABLE & ~PREADY;
      hit_ctrl    = (PADDR == CTRL_ADDR);
      hit_status  = (PADDR == STATUS_ADDR);
      hit_tgreen  = (PADDR == TGREEN_ADDR);
      hit_tyellow = (PADDR == TYELLOW_ADDR);
      hit_cycles  = (PADDR == CYCLES_ADDR);
      apb_err     = access & (~(hit_ctrl | hit_status | hit_tgreen | hit_tyellow | hit_cycles)
                              | (PWRITE & (hit_status | hit_cycles)));
      wr_en       = access & PWRITE & ~apb_err;
   end

   always_comb begin
      status_word              = '0;
      status_word[3:0]         = {lights_a, lights_b};
      status_word[6:4]         = phase;
      status_word[7]           = ctrl_flash;
      status_word[8 +: CNT_W]  = timer;
      rd_word                  = '0;
      if (hit_ctrl)
         rd_word[2:0] = {ctrl_flash, 1'b0, ctrl_en};
      else if (hit_status)
         rd_word = status_word;
      else if (hit_tgreen)
         rd_word[CNT_W-1:0] = t_green;
      else if (hit_tyellow)
         rd_word[CNT_W-1:0] = t_yellow;
      else if (hit_cycles)
         rd_word = cycles;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PREADY     <= 1'b0;
         PSLVERR    <= 1'b0;
         PRDATA     <= '0;
         ctrl_en    <= 1'b1;
         ctrl_adv   <= 1'b0;
         ctrl_flash <= 1'b0;
         t_green    <= CNT_W'(T_GREEN_DEF);
         t_yellow   <= CNT_W'(T_YELLOW_DEF);
      end else begin
         PREADY   <= access;
         PSLVERR  <= apb_err;
         PRDATA   <= (access & ~PWRITE & ~apb_err) ? rd_word : '0;
         ctrl_adv <= 1'b0;   // ADV is a one-cycle strobe
         if (wr_en & hit_ctrl) begin
            ctrl_en    <= PWDATA[0];
            ctrl_adv   <= PWDATA[1];
            ctrl_flash <= PWDATA[2];
         end
         if (wr_en & hit_tgreen)
            t_green <= at_least_one(PWDATA[CNT_W-1:0]);
         if (wr_en & hit_tyellow)
            t_yellow <= at_least_one(PWDATA[CNT_W-1:0]);
      end
   end

   // ---------------------------------------------------------------- phase FSM
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         phase        <= P0;
         timer        <= '0;
         cycles       <= '0;
         flash_active <= 1'b0;
         flash_cnt    <= '0;
         flash_off    <= 1'b0;
         lights_a     <= LAMP_GREEN;
         lights_b     <= LAMP_RED;
      end else begin
         phase        <= phase_nxt;
         timer        <= timer_nxt;
         if (wrap)
            cycles <= cycles + 32'd1;
         flash_active <= flash_active_nxt;
         flash_cnt    <= flash_cnt_nxt;
         flash_off    <= flash_off_nxt;
         lights_a     <= lamp_a_nxt;
         lights_b     <= lamp_b_nxt;
      end
   end

   // flash_active still set while FLASH is cleared gives one resume cycle at P0/0
   always_comb begin
      phase_nxt = phase;
      timer_nxt = timer;
      wrap      = 1'b0;
      dur       = (phase == P0 || phase == P3) ? t_green : t_yellow;
      if (ctrl_flash || flash_active) begin
         phase_nxt = P0;
         timer_nxt = '0;
      end else if (ctrl_en) begin
         if (ctrl_adv || (timer >= dur - ONE)) begin
            wrap      = (phase == P5);
            phase_nxt = (phase == P5) ? P0 : phase + 3'd1;
            timer_nxt = '0;
         end else begin
            timer_nxt = timer + ONE;
         end
      end
   end

   always_comb begin
      flash_active_nxt = ctrl_flash;
      flash_cnt_nxt    = flash_cnt;
      flash_off_nxt    = flash_off;
      lamp_a_nxt       = LAMP_GREEN;
      lamp_b_nxt       = LAMP_RED;
      if (ctrl_flash) begin
         if (!flash_active) begin
            flash_cnt_nxt = '0;
            flash_off_nxt = 1'b0;
         end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt_nxt = '0;
            flash_off_nxt = ~flash_off;
         end else begin
            flash_cnt_nxt = flash_cnt + FLASH_ONE;
         end
         lamp_a_nxt = flash_off_nxt ? LAMP_OFF : LAMP_YELLOW;
         lamp_b_nxt = flash_off_nxt ? LAMP_OFF : LAMP_YELLOW;
      end else begin
         case (phase_nxt)
            P0:      begin lamp_a_nxt = LAMP_GREEN;  lamp_b_nxt = LAMP_RED;    end
            P1:      begin lamp_a_nxt = LAMP_YELLOW; lamp_b_nxt = LAMP_RED;    end
            P2:      begin lamp_a_nxt = LAMP_RED;    lamp_b_nxt = LAMP_YELLOW; end
            P3:      begin lamp_a_nxt = LAMP_RED;    lamp_b_nxt = LAMP_GREEN;  end
            P4:      begin lamp_a_nxt = LAMP_RED;    lamp_b_nxt = LAMP_YELLOW; end
            default: begin lamp_a_nxt = LAMP_YELLOW; lamp_b_nxt = LAMP_RED;    end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_traffic_ctrl_v2.sv
`default_nettype none
// ============================================================================
// tb_apb_traffic_ctrl_v2 : scoreboard bench for the APB traffic-light controller.
// Revision: 1.0
// ============================================================================
module tb_apb_traffic_ctrl_v2;

   localparam int FLASH_HALF = 8;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [1:0]  lights_a;
   logic [1:0]  lights_b;

   always #5 PCLK = ~PCLK;

   apb_traffic_ctrl_v2 #(
      .CNT_W(16), .T_GREEN_DEF(15), .T_YELLOW_DEF(5), .FLASH_HALF(FLASH_HALF),
      .CTRL_ADDR(32'h00), .STATUS_ADDR(32'h04), .TGREEN_ADDR(32'h08),
      .TYELLOW_ADDR(32'h0C), .CYCLES_ADDR(32'h10)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .lights_a(lights_a), .lights_b(lights_b)
   );

   int compared = 0;
   int mismatched = 0;
   bit armed = 1'b0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } resp_t;
   resp_t exp_q[$];

   // Reference model state: phase index, cycles elapsed in phase, registers
   int          m_phase, m_timer, m_tg, m_ty, m_fl_age;
   bit          m_en, m_adv, m_flash, m_fl_on, m_ready;
   logic [31:0] m_cycles;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_lamp(input bit dir_b);
      if (m_fl_on)
         return (((m_fl_age / FLASH_HALF) % 2) == 1) ? 2'b11 : 2'b01;
      case (m_phase)
         0:       return dir_b ? 2'b00 : 2'b10;
         1:       return dir_b ? 2'b00 : 2'b01;
         2:       return dir_b ? 2'b01 : 2'b00;
         3:       return dir_b ? 2'b10 : 2'b00;
         4:       return dir_b ? 2'b01 : 2'b00;
         default: return dir_b ? 2'b00 : 2'b01;
      endcase
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s        = '0;
      s[3:2]   = exp_lamp(1'b0);
      s[1:0]   = exp_lamp(1'b1);
      s[6:4]   = 3'(m_phase);
      s[7]     = m_flash;
      s[23:8]  = 16'(m_timer);
      return s;
   endfunction

   task automatic model_step();
      resp_t r;
      bit    acc;
      if (!PRESETn) begin
         m_phase = 0; m_timer = 0; m_en = 1'b1; m_adv = 1'b0; m_flash = 1'b0;
         m_tg = 15; m_ty = 5; m_cycles = '0; m_fl_on = 1'b0; m_fl_age = 0;
         m_ready = 1'b0;
         exp_q.delete();
      end else begin
         acc    = PSEL && PENABLE && !m_ready;
         r.data = '0;
         r.err  = 1'b0;
         if (acc) begin
            case (PADDR)
               32'h00:  if (!PWRITE) r.data = {29'b0, m_flash, 1'b0, m_en};
               32'h04:  if (PWRITE) r.err = 1'b1; else r.data = m_status();
               32'h08:  if (!PWRITE) r.data = 32'(m_tg);
               32'h0C:  if (!PWRITE) r.data = 32'(m_ty);
               32'h10:  if (PWRITE) r.err = 1'b1; else r.data = m_cycles;
               default: r.err = 1'b1;
            endcase
            exp_q.push_back(r);
         end
         // Light sequencing from the values held before this edge
         if (m_flash) begin
            if (!m_fl_on) begin
               m_fl_on = 1'b1;
               m_fl_age = 0;
            end else begin
               m_fl_age++;
            end
            m_phase = 0;
            m_timer = 0;
         end else if (m_fl_on) begin
            m_fl_on = 1'b0;
            m_phase = 0;
            m_timer = 0;
         end else if (m_en) begin
            if (m_adv || (m_timer + 1 >= ((m_phase == 0 || m_phase == 3) ? m_tg : m_ty))) begin
               if (m_phase == 5) m_cycles++;
               m_phase = (m_phase + 1) % 6;
               m_timer = 0;
            end else begin
               m_timer++;
            end
         end
         m_adv = 1'b0;
         if (acc && PWRITE && !r.err) begin
            case (PADDR)
               32'h00: begin m_en = PWDATA[0]; m_adv = PWDATA[1]; m_flash = PWDATA[2]; end
               32'h08: m_tg = (PWDATA[15:0] == 16'd0) ? 1 : int'(PWDATA[15:0]);
               32'h0C: m_ty = (PWDATA[15:0] == 16'd0) ? 1 : int'(PWDATA[15:0]);
               default: ;
            endcase
         end
         m_ready = acc;
      end
   endtask

   initial forever begin
      @(posedge PCLK);
      model_step();
   end

   // Monitor: lamps and handshake every cycle, responses popped on PREADY
   initial forever begin
      resp_t r;
      @(negedge PCLK);
      if (armed) begin
         chk("pready", 32'(PREADY), 32'(m_ready));
         chk("lights", {28'b0, lights_a, lights_b}, {28'b0, exp_lamp(1'b0), exp_lamp(1'b1)});
         if (PREADY === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pready", 32'(exp_q.size()), 32'd1);
            end else begin
               r = exp_q.pop_front();
               chk("prdata", PRDATA, r.data);
               chk("pslverr", 32'(PSLVERR), 32'(r.err));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_state(input int p, input int t);
      int n;
      n = 0;
      while (!(m_phase == p && m_timer == t) && n < 400) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 400) chk("wait_state_timeout", 32'(m_phase * 1000 + m_timer), 32'(p * 1000 + t));
   endtask

   function automatic logic [31:0] pick_ctrl();
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return 32'd1;
         4, 5, 6:    return 32'd3;
         7:          return 32'd0;
         8:          return 32'd2;
         default:    return 32'd5;
      endcase
   endfunction

   initial begin
      int          sel;
      bit          wr;
      logic [31:0] a, d;

      @(negedge PCLK);
      armed = 1'b1;
      @(negedge PCLK);
      PRESETn = 1'b1;

      // Default sequence and cycle counter
      idle(80);
      apb(1'b0, 32'h10, 32'h0);
      apb(1'b0, 32'h04, 32'h0);

      // Shortened green mid-phase, then 1-cycle yellows
      wait_state(0, 8);
      apb(1'b1, 32'h08, 32'd3);
      apb(1'b1, 32'h0C, 32'd0);
      apb(1'b0, 32'h0C, 32'h0);
      idle(30);
      apb(1'b1, 32'h08, 32'd15);
      apb(1'b1, 32'h0C, 32'h1234_0005);

      // Forced advance, then ADV while frozen
      wait_state(3, 0);
      apb(1'b1, 32'h00, 32'd3);
      apb(1'b0, 32'h00, 32'h0);
      apb(1'b1, 32'h00, 32'd0);
      idle(5);
      apb(1'b1, 32'h00, 32'd2);
      idle(5);
      apb(1'b0, 32'h04, 32'h0);
      apb(1'b1, 32'h00, 32'd1);

      // Night flash and resume
      apb(1'b1, 32'h00, 32'd5);
      idle(40);
      apb(1'b0, 32'h04, 32'h0);
      apb(1'b1, 32'h00, 32'd1);
      idle(10);

      // Error responses
      apb(1'b0, 32'h14, 32'h0);
      apb(1'b1, 32'h04, 32'hFFFF_FFFF);
      apb(1'b1, 32'h10, 32'h5);
      apb(1'b0, 32'h04, 32'h0);

      // Reset during P3, then during the wait state of a T_GREEN write
      wait_state(3, 1);
      @(negedge PCLK); PRESETn = 1'b0;
      @(negedge PCLK); PRESETn = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'd7;
      @(negedge PCLK); PENABLE = 1'b1; PRESETn = 1'b0;
      @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
      apb(1'b0, 32'h08, 32'h0);
      apb(1'b0, 32'h00, 32'h0);
      apb(1'b0, 32'h10, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         wr  = 1'($urandom_range(0, 1));
         d   = $urandom;
         case (sel)
            0, 1, 2: begin a = 32'h00; if (wr) d = pick_ctrl(); end
            3, 4:    begin a = 32'h08; d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 10)); end
            5, 6:    begin a = 32'h0C; d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6)); end
            7:       a = 32'h04;
            8:       a = 32'h10;
            default: a = 32'h14 + 32'(4 * $urandom_range(0, 50));
         endcase
         apb(wr, a, d);
         if (a == 32'h00 && wr && d[2]) idle(24);
         idle($urandom_range(0, 6));
         if ($urandom_range(0, 59) == 0) begin
            @(negedge PCLK); PRESETn = 1'b0;
            @(negedge PCLK); PRESETn = 1'b1;
         end
      end

      idle(5);
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
